// File: rtl/rlbp_result_capture.sv
// Deserialises the RLBP serial result stream into words, buffers them in a FIFO, drains over Wishbone.
// Latency: a completed word is readable one cycle after its last bit; bus ack one cycle after accept.
// Backpressure: none on the serial side (words pushed into a full FIFO are dropped and flagged); bus is ack-based.
module rlbp_result_capture #(
    parameter int WORD_BITS = 8,
    parameter int DEPTH     = 16,
    localparam int LW       = $clog2(DEPTH) + 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ser_data_i,
    input  logic        ser_en_i,
    input  logic        frame_done_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        irq_o
);
    localparam int PW = LW - 1;
    localparam int CW = $clog2(WORD_BITS);

    logic [WORD_BITS-1:0] mem [DEPTH];
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic [LW-1:0]        level;
    logic [WORD_BITS-1:0] shift;
    logic [CW-1:0]        bit_cnt;
    logic                 enable, irq_frame_en, irq_level_en;
    logic [7:0]           threshold;
    logic                 ovf_sticky, frame_sticky;
    logic                 held;

    logic wb_active, tag_hit, hit_data, hit_stat, hit_ctrl, sel, accept, rd_acc, wr_acc;
    logic fifo_empty, fifo_full, pop, flush;
    logic [31:0] rd_data;

    assign wb_active  = wbs_cyc_i & wbs_stb_i;
    assign tag_hit    = (wbs_adr_i[31:28] == 4'h3);
    assign hit_data   = (wbs_adr_i[7:0] == 8'h80);
    assign hit_stat   = (wbs_adr_i[7:0] == 8'h84);
    assign hit_ctrl   = (wbs_adr_i[7:0] == 8'h88);
    assign sel        = wb_active & tag_hit & (hit_data | hit_stat | hit_ctrl);
    // held blocks re-acceptance while the master keeps stb asserted after its ack
    assign accept     = sel & ~held;
    assign rd_acc     = accept & ~wbs_we_i;
    assign wr_acc     = accept & wbs_we_i;
    assign fifo_empty = (level == '0);
    assign fifo_full  = (level == LW'(DEPTH));
    assign pop        = rd_acc & hit_data & ~fifo_empty;
    assign flush      = wr_acc & hit_ctrl & wbs_sel_i[0] & wbs_dat_i[1];

    logic unused;
    assign unused = ^{wbs_sel_i[3:2], wbs_dat_i[31:16], wbs_dat_i[7:4], wbs_adr_i[27:8]};

    logic                 bit_in, fd_in, push_req, deser_clear, push_ok, drop;
    logic [CW:0]          cnt_inc;
    logic [WORD_BITS-1:0] shift_nx, push_word;

    always_comb begin
        bit_in      = enable & ser_en_i;
        fd_in       = enable & frame_done_i;
        shift_nx    = bit_in ? {shift[WORD_BITS-2:0], ser_data_i} : shift;
        cnt_inc     = {1'b0, bit_cnt} + {{CW{1'b0}}, bit_in};
        push_req    = 1'b0;
        deser_clear = 1'b0;
        push_word   = shift_nx;
        if (cnt_inc == (CW+1)'(WORD_BITS)) begin
            push_req    = 1'b1;
            deser_clear = 1'b1;
        end else if (fd_in && cnt_inc != '0) begin
            // partial word: collected bits sit in the LSBs, move them to the top
            push_req    = 1'b1;
            deser_clear = 1'b1;
            push_word   = shift_nx << (WORD_BITS - int'(cnt_inc));
        end
    end

    assign push_ok = push_req & ~flush & (~fifo_full | pop);
    assign drop    = push_req & ~flush & fifo_full & ~pop;

    always_comb begin
        rd_data = '0;
        if (hit_data && !fifo_empty) begin
            rd_data = {1'b1, {(31-WORD_BITS){1'b0}}, mem[rd_ptr]};
        end else if (hit_stat) begin
            rd_data[0]       = fifo_empty;
            rd_data[1]       = fifo_full;
            rd_data[2]       = ovf_sticky;
            rd_data[3]       = frame_sticky;
            rd_data[4]       = (bit_cnt != '0);
            rd_data[8 +: LW] = level;
        end else if (hit_ctrl) begin
            rd_data = {16'd0, threshold, 4'd0, irq_level_en, irq_frame_en, 1'b0, enable};
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wbs_ack_o    <= 1'b0;
            wbs_dat_o    <= '0;
            irq_o        <= 1'b0;
            held         <= 1'b0;
            enable       <= 1'b0;
            irq_frame_en <= 1'b0;
            irq_level_en <= 1'b0;
            threshold    <= '0;
            ovf_sticky   <= 1'b0;
            frame_sticky <= 1'b0;
            shift        <= '0;
            bit_cnt      <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
        end else begin
            wbs_ack_o <= accept;
            if (accept) begin
                wbs_dat_o <= wbs_we_i ? 32'd0 : rd_data;
                held      <= 1'b1;
            end else if (!wb_active) begin
                held <= 1'b0;
            end

            if (wr_acc && hit_ctrl) begin
                if (wbs_sel_i[0]) begin
                    enable       <= wbs_dat_i[0];
                    irq_frame_en <= wbs_dat_i[2];
                    irq_level_en <= wbs_dat_i[3];
                end
                if (wbs_sel_i[1]) begin
                    threshold <= wbs_dat_i[15:8];
                end
            end

            if (drop) begin
                ovf_sticky <= 1'b1;
            end else if (wr_acc && hit_stat && wbs_sel_i[0] && wbs_dat_i[2]) begin
                ovf_sticky <= 1'b0;
            end
            if (fd_in) begin
                frame_sticky <= 1'b1;
            end else if (wr_acc && hit_stat && wbs_sel_i[0] && wbs_dat_i[3]) begin
                frame_sticky <= 1'b0;
            end

            if (flush || deser_clear) begin
                shift   <= '0;
                bit_cnt <= '0;
            end else begin
                shift   <= shift_nx;
                bit_cnt <= cnt_inc[CW-1:0];
            end

            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + PW'(1);
                if (pop)     rd_ptr <= rd_ptr + PW'(1);
                case ({push_ok, pop})
                    2'b10:   level <= level + LW'(1);
                    2'b01:   level <= level - LW'(1);
                    default: level <= level;
                endcase
            end

            irq_o <= (irq_frame_en & frame_sticky)
                   | (irq_level_en & (threshold != 8'd0) & (16'(level) >= 16'(threshold)))
                   | ovf_sticky;
        end
    end
endmodule

// File: tb/tb_rlbp_result_capture.sv
// Bench for rlbp_result_capture: directed scenarios plus random serial/bus traffic,
// checked against a queue-based model of words, pending bits and sticky flags.
module tb_rlbp_result_capture;
    localparam int W = 8;
    localparam int D = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        ser_data_i, ser_en_i, frame_done_i;
    logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i, wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        irq_o;

    always #5 clk = ~clk;

    rlbp_result_capture #(.WORD_BITS(W), .DEPTH(D)) dut (
        .clk(clk), .rst(rst),
        .ser_data_i(ser_data_i), .ser_en_i(ser_en_i), .frame_done_i(frame_done_i),
        .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o), .irq_o(irq_o)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int q[$];
    int pbits[$];
    bit m_en, m_ovf, m_frm, m_ife, m_ile;
    int m_thr;

    function automatic int pack();
        int w = 0;
        foreach (pbits[i]) w |= pbits[i] << (W - 1 - i);
        return w;
    endfunction

    function automatic void m_push(int w);
        if (q.size() >= D) m_ovf = 1'b1;
        else q.push_back(w);
    endfunction

    function automatic void m_bit(int b);
        if (!m_en) return;
        pbits.push_back(b);
        if (pbits.size() == W) begin
            m_push(pack());
            pbits.delete();
        end
    endfunction

    function automatic void m_frame();
        if (!m_en) return;
        m_frm = 1'b1;
        if (pbits.size() > 0) begin
            m_push(pack());
            pbits.delete();
        end
    endfunction

    function automatic logic [31:0] m_status();
        logic [31:0] s = '0;
        s[0]      = (q.size() == 0);
        s[1]      = (q.size() == D);
        s[2]      = m_ovf;
        s[3]      = m_frm;
        s[4]      = (pbits.size() != 0);
        s[15:8]   = 8'(q.size());
        return s;
    endfunction

    function automatic logic m_irq();
        return (m_ife && m_frm) || (m_ile && m_thr != 0 && q.size() >= m_thr) || m_ovf;
    endfunction

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ser(input int b, input bit fd);
        ser_en_i = 1'b1; ser_data_i = b[0]; frame_done_i = fd;
        tick();
        ser_en_i = 1'b0; ser_data_i = 1'b0; frame_done_i = 1'b0;
        m_bit(b);
        if (fd) m_frame();
    endtask

    task automatic send_word(input int w);
        for (int i = W - 1; i >= 0; i--) ser((w >> i) & 1, 1'b0);
    endtask

    task automatic wb(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                      input logic [3:0] sel, output logic [31:0] rd, output int acks);
        wbs_adr_i = adr; wbs_we_i = we; wbs_dat_i = dat; wbs_sel_i = sel;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
        rd = '0; acks = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (wbs_ack_o) begin
                acks++;
                rd = wbs_dat_o;
                break;
            end
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        tick();
    endtask

    task automatic rd_data(input string tag, output logic [31:0] rd);
        int a;
        logic [31:0] exp;
        wb(32'h3000_0080, 1'b0, 32'd0, 4'hF, rd, a);
        exp = (q.size() > 0) ? (32'h8000_0000 | 32'(q.pop_front())) : 32'd0;
        check({tag, "_ack"}, 32'(a), 32'd1);
        check(tag, rd, exp);
    endtask

    task automatic rd_status(input string tag);
        int a;
        logic [31:0] rd;
        wb(32'h3000_0084, 1'b0, 32'd0, 4'hF, rd, a);
        check(tag, rd, m_status());
    endtask

    task automatic wr_ctrl(input logic [31:0] v);
        int a;
        logic [31:0] rd;
        wb(32'h3000_0088, 1'b1, v, 4'h3, rd, a);
        m_en = v[0]; m_ife = v[2]; m_ile = v[3]; m_thr = int'(v[15:8]);
        if (v[1]) begin
            q.delete();
            pbits.delete();
        end
    endtask

    task automatic wr_status(input logic [31:0] v);
        int a;
        logic [31:0] rd;
        wb(32'h3000_0084, 1'b1, v, 4'h1, rd, a);
        if (v[2]) m_ovf = 1'b0;
        if (v[3]) m_frm = 1'b0;
    endtask

    function automatic void m_reset();
        q.delete(); pbits.delete();
        m_en = 0; m_ovf = 0; m_frm = 0; m_ife = 0; m_ile = 0; m_thr = 0;
    endfunction

    initial begin
        logic [31:0] rd;
        int a, w, last;
        ser_data_i = 0; ser_en_i = 0; frame_done_i = 0;
        wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0; wbs_sel_i = 0; wbs_adr_i = 0; wbs_dat_i = 0;
        m_reset();
        rst = 1'b1;
        repeat (3) tick();
        check("rst_ack", 32'(wbs_ack_o), 32'd0);
        check("rst_dat", wbs_dat_o, 32'd0);
        check("rst_irq", 32'(irq_o), 32'd0);
        rst = 1'b0;
        tick();
        rd_status("rst_status");

        // basic two-word stream
        wr_ctrl(32'h1);
        send_word(8'hA3);
        send_word(8'h5C);
        rd_status("t1_status");
        rd_data("t1_rd0", rd);
        check("t1_rd0_lit", rd, 32'h8000_00A3);
        rd_data("t1_rd1", rd);
        check("t1_rd1_lit", rd, 32'h8000_005C);
        rd_data("t1_rd_empty", rd);

        // partial word closed by frame_done on the last strobe
        ser(1, 0); ser(1, 0); ser(0, 1);
        rd_status("t2_status");
        rd_data("t2_rd", rd);
        check("t2_rd_lit", rd, 32'h8000_00C0);
        wr_status(32'h8);
        rd_status("t2_status_clr");

        // overflow
        for (int i = 0; i < D + 1; i++) send_word(int'($urandom_range(0, 255)));
        rd_status("t3_status");
        check("t3_irq", 32'(irq_o), 32'(m_irq()));
        for (int i = 0; i < D; i++) rd_data("t3_drain", rd);
        wr_status(32'h4);

        // full FIFO: word completion coincides with a pop
        for (int i = 0; i < D; i++) send_word(int'($urandom_range(0, 255)));
        w = int'($urandom_range(0, 255));
        for (int i = W - 1; i >= 1; i--) ser((w >> i) & 1, 1'b0);
        wbs_adr_i = 32'h3000_0080; wbs_we_i = 0; wbs_sel_i = 4'hF; wbs_cyc_i = 1; wbs_stb_i = 1;
        ser_en_i = 1; ser_data_i = w[0];
        tick();
        check("t4_ack", 32'(wbs_ack_o), 32'd1);
        check("t4_rd", wbs_dat_o, 32'h8000_0000 | 32'(q.pop_front()));
        ser_en_i = 0; ser_data_i = 0; wbs_cyc_i = 0; wbs_stb_i = 0;
        m_bit(w & 1);
        tick();
        rd_status("t4_status");
        last = 0;
        for (int i = 0; i < D; i++) begin
            rd_data("t4_drain", rd);
            last = int'(rd[7:0]);
        end
        check("t4_last", 32'(last), 32'(w));

        // level threshold interrupt and flush
        wr_ctrl(32'h0509);
        for (int i = 0; i < 4; i++) send_word(int'($urandom_range(0, 255)));
        tick();
        check("t5_irq_lvl4", 32'(irq_o), 32'd0);
        send_word(int'($urandom_range(0, 255)));
        check("t5_irq_same", 32'(irq_o), 32'd0);
        tick();
        check("t5_irq_rise", 32'(irq_o), 32'd1);
        rd_data("t5_pop", rd);
        check("t5_irq_fall", 32'(irq_o), 32'(m_irq()));
        wr_ctrl(32'h050B);
        rd_status("t5_flush_status");
        check("t5_flush_irq", 32'(irq_o), 32'd0);

        // held strobe and unmapped addresses
        wr_ctrl(32'h1);
        send_word(8'h11);
        send_word(8'h22);
        wbs_adr_i = 32'h3000_0080; wbs_we_i = 0; wbs_sel_i = 4'hF; wbs_cyc_i = 1; wbs_stb_i = 1;
        a = 0; rd = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (wbs_ack_o) begin a++; rd = wbs_dat_o; end
        end
        wbs_cyc_i = 0; wbs_stb_i = 0;
        tick();
        check("t6_held_acks", 32'(a), 32'd1);
        check("t6_held_rd", rd, 32'h8000_0000 | 32'(q.pop_front()));
        rd_status("t6_status");
        wb(32'h3000_0090, 1'b0, 32'd0, 4'hF, rd, a);
        check("t6_unmapped_acks", 32'(a), 32'd0);
        wb(32'h2000_0080, 1'b0, 32'd0, 4'hF, rd, a);
        check("t6_wrongtag_acks", 32'(a), 32'd0);
        rd_status("t6_status2");

        // random traffic
        for (int n = 0; n < 400; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 60) begin
                ser(int'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
            end else if (r < 75) begin
                rd_data("rnd_data", rd);
            end else if (r < 85) begin
                rd_status("rnd_status");
                check("rnd_irq", 32'(irq_o), 32'(m_irq()));
            end else if (r < 90) begin
                wr_ctrl({28'd0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 5) == 0),
                         1'($urandom_range(0, 3) != 0)});
            end else if (r < 95) begin
                wr_status(32'($urandom_range(0, 15)));
            end else begin
                tick();
            end
        end
        rd_status("rnd_final_status");

        // reset in the middle of a word
        wr_ctrl(32'h1);
        ser(1, 0); ser(0, 0); ser(1, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_reset();
        tick();
        rd_status("midrst_status");
        wr_ctrl(32'h1);
        send_word(8'h3C);
        rd_data("midrst_rd", rd);
        check("midrst_rd_lit", rd, 32'h8000_003C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
